// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues I-mem requests, resolves redirects and stalls.
// Optional perf counters are built only when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_br_taken,
    input  logic [15:0] ex_br_target,
    input  logic        ex_jr_valid,
    input  logic [15:0] ex_jr_target,
    input  logic        id_jmp_valid,
    input  logic [15:0] id_jmp_target,
    input  logic        hazard_stall,
    input  logic        halt,
    input  logic        imem_done,
    input  logic        imem_stall,
    input  logic [15:0] imem_data,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    output logic [15:0] pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc2,
    output logic        flush_ifid,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_kill_cnt
);
    localparam int unsigned W = 16;
    localparam logic [W-1:0] PC_STEP = W'(2);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALTED} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d, buf_q, buf_d;
    logic           kill_q, kill_d;
    logic           ex_redir, redir, halt_acc, deliver, stall_inc, kill_inc;
    logic [W-1:0]   redir_target, dlv_data, pc_inc;

    // Halt sits in ID, so it cannot coexist with an ID jump; EX redirects beat both.
    assign ex_redir = ex_br_taken | ex_jr_valid;
    assign redir    = ex_redir | (id_jmp_valid & ~hazard_stall & ~halt);
    assign halt_acc = halt & ~hazard_stall & ~ex_redir;
    assign pc_inc   = pc_q + PC_STEP;

    always_comb begin
        if (ex_br_taken)      redir_target = ex_br_target;
        else if (ex_jr_valid) redir_target = ex_jr_target;
        else                  redir_target = id_jmp_target;
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign if_pc2    = rst ? pc_inc : W'(2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            buf_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        kill_d     = kill_q;
        imem_en    = 1'b0;
        if_valid   = 1'b0;
        if_instr   = '0;
        flush_ifid = 1'b0;
        deliver    = 1'b0;
        dlv_data   = '0;
        stall_inc  = 1'b0;
        kill_inc   = 1'b0;

        case (state_q)
            S_FETCH: begin
                stall_inc = imem_stall;
                imem_en   = ~imem_stall & ~halt_acc;
                if (redir) begin
                    flush_ifid = 1'b1;
                    pc_d       = redir_target;
                    // A request already on the bus is wrong-path: drop it now or on return.
                    if (!imem_stall) begin
                        if (imem_done) begin
                            kill_inc = 1'b1;
                        end else begin
                            kill_d  = 1'b1;
                            state_d = S_WAIT;
                        end
                    end
                end else if (halt_acc) begin
                    state_d = S_HALTED;
                end else if (!imem_stall) begin
                    if (imem_done) begin
                        deliver  = 1'b1;
                        dlv_data = imem_data;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_inc = 1'b1;
                if (redir) begin
                    flush_ifid = 1'b1;
                    pc_d       = redir_target;
                    if (imem_done) begin
                        kill_inc = 1'b1;
                        kill_d   = 1'b0;
                        state_d  = S_FETCH;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (halt_acc) begin
                    kill_d  = 1'b0;
                    state_d = S_HALTED;
                end else if (imem_done) begin
                    if (kill_q) begin
                        kill_inc = 1'b1;
                        kill_d   = 1'b0;
                        state_d  = S_FETCH;
                    end else begin
                        deliver  = 1'b1;
                        dlv_data = imem_data;
                    end
                end
            end
            S_HOLD: begin
                if (redir) begin
                    flush_ifid = 1'b1;
                    pc_d       = redir_target;
                    kill_inc   = 1'b1;
                    state_d    = S_FETCH;
                end else if (halt_acc) begin
                    state_d = S_HALTED;
                end else begin
                    if_valid = 1'b1;
                    if_instr = buf_q;
                    if (!hazard_stall) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            default: ;
        endcase

        if (deliver) begin
            if (!hazard_stall) begin
                if_valid = 1'b1;
                if_instr = dlv_data;
                pc_d     = pc_inc;
                state_d  = S_FETCH;
            end else begin
                buf_d   = dlv_data;
                state_d = S_HOLD;
            end
        end

        if (!rst) begin
            imem_en    = 1'b0;
            if_valid   = 1'b0;
            flush_ifid = 1'b0;
            if_instr   = '0;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [W-1:0] stall_cnt_q, stall_cnt_d, kill_cnt_q, kill_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + W'(1);
        if (kill_inc && kill_cnt_q != '1)   kill_cnt_d  = kill_cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_kill_cnt  = kill_cnt_q;
`else
    logic unused_perf;
    assign unused_perf    = stall_inc ^ kill_inc;
    assign perf_stall_cnt = '0;
    assign perf_kill_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl, plus halt/reset sequences.
module tb_fetch_ctrl;
`ifdef FETCH_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_br_taken, ex_jr_valid, id_jmp_valid, hazard_stall, halt, imem_done, imem_stall;
    logic [15:0] ex_br_target, ex_jr_target, id_jmp_target, imem_data;
    logic        imem_en, if_valid, flush_ifid;
    logic [15:0] imem_addr, pc, if_instr, if_pc2, perf_stall_cnt, perf_kill_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_jr_valid(ex_jr_valid), .ex_jr_target(ex_jr_target),
        .id_jmp_valid(id_jmp_valid), .id_jmp_target(id_jmp_target),
        .hazard_stall(hazard_stall), .halt(halt),
        .imem_done(imem_done), .imem_stall(imem_stall), .imem_data(imem_data),
        .imem_en(imem_en), .imem_addr(imem_addr), .pc(pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc2(if_pc2),
        .flush_ifid(flush_ifid),
        .perf_stall_cnt(perf_stall_cnt), .perf_kill_cnt(perf_kill_cnt)
    );

    typedef struct {
        logic        done, stall, hz, hlt, br;
        logic [15:0] br_t;
        logic        jr;
        logic [15:0] jr_t;
        logic        jmp;
        logic [15:0] jmp_t, data;
        logic        e_en;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr, e_pc2;
        logic        e_flush;
        logic [15:0] e_sc, e_kc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] pf(input int unsigned x);
        return PERF_ON ? 16'(x) : 16'h0000;
    endfunction

    function automatic vec_t mk(
        input logic done, stall, hz, hlt, br, input logic [15:0] br_t,
        input logic jr, input logic [15:0] jr_t, input logic jmp, input logic [15:0] jmp_t,
        input logic [15:0] data, input logic e_en, input logic [15:0] e_addr,
        input logic e_valid, input logic [15:0] e_instr, input logic [15:0] e_pc2,
        input logic e_flush, input int unsigned sc, input int unsigned kc);
        vec_t v;
        v.done = done; v.stall = stall; v.hz = hz; v.hlt = hlt; v.br = br; v.br_t = br_t;
        v.jr = jr; v.jr_t = jr_t; v.jmp = jmp; v.jmp_t = jmp_t; v.data = data;
        v.e_en = e_en; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
        v.e_pc2 = e_pc2; v.e_flush = e_flush; v.e_sc = pf(sc); v.e_kc = pf(kc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        ex_br_taken = 0; ex_br_target = 16'h0; ex_jr_valid = 0; ex_jr_target = 16'h0;
        id_jmp_valid = 0; id_jmp_target = 16'h0; hazard_stall = 0; halt = 0;
        imem_done = 0; imem_stall = 0; imem_data = 16'h0;
    endtask

    task automatic drive(input vec_t v);
        imem_done = v.done; imem_stall = v.stall; hazard_stall = v.hz; halt = v.hlt;
        ex_br_taken = v.br; ex_br_target = v.br_t; ex_jr_valid = v.jr; ex_jr_target = v.jr_t;
        id_jmp_valid = v.jmp; id_jmp_target = v.jmp_t; imem_data = v.data;
    endtask

    initial begin
        // done stall hz halt | br tgt | jr tgt | jmp tgt | data || en addr valid instr pc2 flush sc kc
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'h1111, 1,16'h0000,1,16'h1111,16'h0002,0, 0,0));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'h2222, 1,16'h0002,1,16'h2222,16'h0004,0, 0,0));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'h3333, 1,16'h0004,1,16'h3333,16'h0006,0, 0,0));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 1,16'h0010, 16'h4444, 1,16'h0006,0,16'h0000,16'h0008,1, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,      16'h0000, 1,16'h0010,0,16'h0000,16'h0012,0, 0,1));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,      16'h0000, 0,16'h0010,0,16'h0000,16'h0012,0, 0,1));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,      16'h0000, 0,16'h0010,0,16'h0000,16'h0012,0, 1,1));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'h5555, 0,16'h0010,1,16'h5555,16'h0012,0, 2,1));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,      16'h0000, 1,16'h0012,0,16'h0000,16'h0014,0, 3,1));
        vecs.push_back(mk(0,0,0,0, 1,16'h0040, 0,0, 0,0, 16'h0000, 0,16'h0012,0,16'h0000,16'h0014,1, 3,1));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'h6666, 0,16'h0040,0,16'h0000,16'h0042,0, 4,1));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'h7777, 1,16'h0040,1,16'h7777,16'h0042,0, 5,2));
        vecs.push_back(mk(0,1,0,0, 0,0, 1,16'h0020, 0,0, 16'h0000, 0,16'h0042,0,16'h0000,16'h0044,1, 5,2));
        vecs.push_back(mk(1,0,1,0, 0,0, 0,0, 0,0,      16'hA0A0, 1,16'h0020,0,16'h0000,16'h0022,0, 6,2));
        vecs.push_back(mk(0,0,1,0, 0,0, 0,0, 0,0,      16'hDEAD, 0,16'h0020,1,16'hA0A0,16'h0022,0, 6,2));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,      16'hDEAD, 0,16'h0020,1,16'hA0A0,16'h0022,0, 6,2));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'hB0B0, 1,16'h0022,1,16'hB0B0,16'h0024,0, 6,2));
        vecs.push_back(mk(0,0,0,0, 1,16'h0100, 1,16'h0200, 1,16'h0300, 16'h0000, 1,16'h0024,0,16'h0000,16'h0026,1, 6,2));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'hC0C0, 0,16'h0100,0,16'h0000,16'h0102,0, 6,2));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'hD0D0, 1,16'h0100,1,16'hD0D0,16'h0102,0, 7,3));
        vecs.push_back(mk(0,1,0,0, 0,0, 1,16'h0200, 1,16'h0300, 16'h0000, 0,16'h0102,0,16'h0000,16'h0104,1, 7,3));
        vecs.push_back(mk(1,0,1,0, 0,0, 0,0, 1,16'h0300, 16'hE0E0, 1,16'h0200,0,16'h0000,16'h0202,0, 8,3));
        vecs.push_back(mk(0,0,1,0, 1,16'h0400, 0,0, 0,0, 16'h0000, 0,16'h0200,0,16'h0000,16'h0202,1, 8,3));
        vecs.push_back(mk(0,1,0,0, 1,16'hFFFE, 0,0, 0,0, 16'h0000, 0,16'h0400,0,16'h0000,16'h0402,1, 8,4));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'h1234, 1,16'hFFFE,1,16'h1234,16'h0000,0, 9,4));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,      16'h4321, 1,16'h0000,1,16'h4321,16'h0002,0, 9,4));
        vecs.push_back(mk(0,1,0,1, 1,16'h0050, 0,0, 0,0, 16'h0000, 0,16'h0002,0,16'h0000,16'h0004,1, 9,4));
        vecs.push_back(mk(1,0,0,1, 0,0, 0,0, 0,0,      16'h9999, 0,16'h0050,0,16'h0000,16'h0052,0, 10,4));

        idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", {imem_en, pc, if_valid, if_instr, if_pc2, flush_ifid, perf_stall_cnt, perf_kill_cnt},
            {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0002, 1'b0, 16'h0000, 16'h0000});
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d", i),
                {imem_en, imem_addr, if_valid, if_instr, if_pc2, flush_ifid, perf_stall_cnt, perf_kill_cnt},
                {vecs[i].e_en, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc2,
                 vecs[i].e_flush, vecs[i].e_sc, vecs[i].e_kc});
            @(negedge clk);
        end

        // Halted: nothing but reset gets out.
        for (int i = 0; i < 10; i++) begin
            idle();
            imem_done = i[0];
            imem_data = 16'hBEEF;
            ex_br_taken = (i == 5);
            ex_br_target = 16'h0100;
            #1;
            chk($sformatf("halted%0d", i), {imem_en, if_valid, pc}, {1'b0, 1'b0, 16'h0050});
            @(negedge clk);
        end
        idle();
        #1;
        chk("perf_after_halt", {perf_stall_cnt, perf_kill_cnt}, {pf(10), pf(4)});

        rst = 1'b0;
        #1;
        chk("reset_cycle_outputs", {imem_en, if_valid, flush_ifid}, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("restart_fetch", {imem_en, imem_addr, perf_stall_cnt, perf_kill_cnt},
            {1'b1, 16'h0000, 16'h0000, 16'h0000});
        imem_done = 1'b1;
        imem_data = 16'h5A5A;
        #1;
        chk("restart_hit", {if_valid, if_instr, if_pc2}, {1'b1, 16'h5A5A, 16'h0002});
        @(negedge clk);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
